// File: rtl/cute_pkg.sv
// cute processor fetch sequencer: shared state encoding,
// opcode field and reserved instruction words.
package cute_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    EXEC,
    IMM_FETCH,
    IMM_LOAD,
    IMM_WAIT,
    HALT,
    FAULT
  } state_t;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;

  localparam logic [2:0] CUTE_IMM_OP    = 3'b001;
  localparam logic [8:0] CUTE_HALT_WORD = 9'b100000000;

  function automatic logic [2:0] op_of(
    input logic [8:0] w
  );
    return w[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/cute_watchdog.sv
// Done watchdog: counts cycles spent waiting on the
// processor and flags expiry at TIMEOUT.
module cute_watchdog
  import cute_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  // The Run cycle itself is count 1, so expiry
  // lands exactly TIMEOUT cycles after Run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= W'(1);
    end else if (i_en && r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt >= W'(TIMEOUT - 1));

endmodule

// File: rtl/cute_fetch_sequencer.sv
// cute program sequencer: fetches ROM words, issues Run,
// serves immediates, tracks halt, faults and retirement.
module cute_fetch_sequencer
  import cute_pkg::*;
#(
  parameter int         PC_W       = 6,
  parameter int         PROG_DEPTH = 64,
  parameter logic [8:0] HALT_WORD  = CUTE_HALT_WORD,
  parameter logic [2:0] IMM_OP     = CUTE_IMM_OP,
  parameter int         TIMEOUT    = 255,
  parameter int         CNT_W      = 16
) (
  input  logic            clk,
  input  logic            Resetn,
  input  logic            start,
  output logic [PC_W-1:0] mem_addr,
  input  logic [8:0]      mem_data,
  output logic [8:0]      DIN,
  output logic            Run,
  input  logic            done,
  input  logic            imm_req,
  output logic            imm_valid,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  output logic [PC_W-1:0] pc,
  output logic [CNT_W-1:0] retired,
  output logic            halted,
  output logic            fault
);

  localparam logic [PC_W-1:0] LAST =
    PC_W'(PROG_DEPTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [8:0]       r_din;
  logic [CNT_W-1:0] r_retired;

  logic w_din_ld;
  logic w_retire;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_exp;
  logic w_tgt_ok;
  logic w_at_last;
  logic w_is_imm;

  assign w_tgt_ok  = int'(jmp_target) < PROG_DEPTH;
  assign w_at_last = (r_pc == LAST);
  assign w_is_imm  = (op_of(r_din) == IMM_OP);

  cute_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .i_clk     (clk),
    .i_rst_n   (Resetn),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_wd_exp)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_din_ld    = 1'b0;
    w_retire    = 1'b0;
    w_wd_clr    = 1'b0;
    w_wd_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = FETCH;
      end
      FETCH: begin
        w_state_nxt = LOAD;
      end
      LOAD: begin
        w_din_ld = 1'b1;
        if (mem_data == HALT_WORD) w_state_nxt = HALT;
        else                       w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_wd_clr    = 1'b1;
        w_state_nxt = EXEC;
      end
      EXEC, IMM_WAIT: begin
        w_wd_en = 1'b1;
        if (done) begin
          w_retire = 1'b1;
          if (jmp) begin
            if (w_tgt_ok) begin
              w_pc_nxt    = jmp_target;
              w_state_nxt = FETCH;
            end else begin
              w_state_nxt = FAULT;
            end
          end else if (w_at_last) begin
            w_state_nxt = FAULT;
          end else begin
            w_pc_nxt    = r_pc + 1'b1;
            w_state_nxt = FETCH;
          end
        end else if (imm_req && r_state == EXEC
                     && w_is_imm) begin
          if (w_at_last) begin
            w_state_nxt = FAULT;
          end else begin
            w_pc_nxt    = r_pc + 1'b1;
            w_state_nxt = IMM_FETCH;
          end
        end else if (w_wd_exp) begin
          w_state_nxt = FAULT;
        end
      end
      IMM_FETCH: begin
        w_din_ld    = 1'b1;
        w_state_nxt = IMM_LOAD;
      end
      IMM_LOAD: begin
        w_state_nxt = IMM_WAIT;
      end
      HALT, FAULT: begin
        if (start) begin
          w_pc_nxt    = '0;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_din     <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_din_ld) r_din <= mem_data;
      if (w_retire && r_retired != '1) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  // Address tracks next pc so the immediate word is
  // already in flight when IMM_FETCH begins.
  assign mem_addr  = w_pc_nxt;
  assign pc        = r_pc;
  assign DIN       = r_din;
  assign retired   = r_retired;
  assign Run       = (r_state == ISSUE);
  assign imm_valid = (r_state == IMM_LOAD);
  assign halted    = (r_state == HALT);
  assign fault     = (r_state == FAULT);

endmodule

// File: doc/cute_fetch_sequencer.md
Name: cute_fetch_sequencer

Overview:
- Program sequencer for the cute processor. Fetches 9-bit instruction words from a synchronous instruction ROM and presents them on DIN, pulsing Run once per instruction.
- Waits for the processor's done, then advances the PC or loads a jump target taken from bus[5:0].
- Replaces the ad-hoc Run/PC glue in the processor top level, adding halt detection, immediate-word fetch, an out-of-range fault and a done watchdog.

Parameters:
- PC_W, 6, PC and instruction address width.
- PROG_DEPTH, 64, number of valid ROM words; legal addresses are 0..PROG_DEPTH-1.
- HALT_WORD, 9'b100000000, instruction word that stops sequencing.
- IMM_OP, 3'b001, opcode in DIN[8:6] whose immediate is the following word.
- TIMEOUT, 255, maximum cycles in EXEC or IMM_WAIT without done before fault.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- start  in  1  level; begin or restart execution at address 0.
- mem_addr  out  PC_W  ROM address; data returns one cycle later.
- mem_data  in  9  ROM read data.
- DIN  out  9  instruction/immediate word to processor (registered).
- Run  out  1  one-cycle pulse; DIN holds a new instruction.
- done  in  1  processor finished the current instruction.
- imm_req  in  1  processor requests the immediate word (IMM_OP only).
- imm_valid  out  1  one-cycle pulse; DIN now holds the immediate.
- jmp  in  1  sampled with done; take the branch.
- jmp_target  in  PC_W  branch target (bus[5:0]), sampled with done.
- pc  out  PC_W  current instruction address.
- retired  out  CNT_W  count of completed instructions, saturating.
- halted  out  1  HALT_WORD reached.
- fault  out  1  address overflow, bad jump target or watchdog expiry.

Behaviour:
- Reset: state IDLE; pc=0, mem_addr=0, DIN=0, Run=0, imm_valid=0, retired=0, halted=0, fault=0, watchdog=0.
- IDLE: when start=1, go to FETCH.
- FETCH: mem_addr=pc, then go to LOAD.
- LOAD: DIN<=mem_data.
  - If mem_data==HALT_WORD, go to HALT and do not pulse Run.
  - Otherwise go to ISSUE.
- ISSUE: Run=1 for exactly one cycle, clear the watchdog, go to EXEC.
- Fetch-to-Run latency is 3 cycles (FETCH, LOAD, ISSUE).
- EXEC: Run=0 and DIN held stable. The watchdog increments each cycle. Events, in priority order:
  - done=1: retired++ (saturates at all-ones).
    - If jmp=1 and jmp_target<PROG_DEPTH: pc<=jmp_target.
    - If jmp=1 and jmp_target>=PROG_DEPTH: go to FAULT.
    - If jmp=0 and pc==PROG_DEPTH-1: go to FAULT (no wrap-around).
    - Otherwise pc<=pc+1.
    - Then go to FETCH.
  - imm_req=1 with done=0, DIN[8:6]==IMM_OP and pc<PROG_DEPTH-1: pc<=pc+1, go to IMM_FETCH.
  - imm_req=1 when the opcode is not IMM_OP: ignored.
  - imm_req=1 with pc==PROG_DEPTH-1: go to FAULT.
  - done and imm_req together: done wins, imm_req dropped.
  - Watchdog reaches TIMEOUT: go to FAULT.
- IMM_FETCH: mem_addr=pc, then go to IMM_LOAD.
- IMM_LOAD: DIN<=mem_data, imm_valid=1 for one cycle, go to IMM_WAIT.
- Immediate latency: imm_valid arrives 2 cycles after imm_req.
- IMM_WAIT: identical to EXEC for done, jmp and the watchdog (pc already points at the immediate word). Further imm_req is ignored.
- HALT: halted=1. start=1 resets pc=0, clears halted, goes to FETCH. retired is kept.
- FAULT: fault=1, Run never asserted. start=1 clears fault, pc=0, goes to FETCH.
- start in any other state is ignored.
- done outside EXEC/IMM_WAIT is ignored.
- Resetn low at any point, including mid-instruction, returns all outputs to reset values asynchronously.
- Sequencing resumes only via start after Resetn deasserts.

Decomposition:
- Shared package cute_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, ISSUE, EXEC, IMM_FETCH, IMM_LOAD, IMM_WAIT, HALT, FAULT);
  - the opcode field slice [8:6];
  - the IMM_OP and HALT_WORD constants.
- One sub-module, cute_watchdog: counter with clear, enable, and an expired output at TIMEOUT.
- The PC/next-address logic stays inline.

Test Plan:
- Straight-line: ROM[0..2] non-IMM, ROM[3]=9'b100000000, done returned 2 cycles after each Run.
  - Run pulses for addresses 0,1,2 with the first Run 3 cycles after start.
  - halted=1 with pc=3; retired=3.
- Jump: ROM[1] done with jmp=1, jmp_target=5.
  - Next mem_addr=5 and pc=5.
  - jmp_target=6'd63 with PROG_DEPTH=6 → fault=1 and no further Run.
- Immediate: ROM[0]=9'b001000001, ROM[1]=9'd68, imm_req 1 cycle after Run.
  - imm_valid 2 cycles later with DIN=9'd68.
  - After done, next fetch is address 2.
- Watchdog: TIMEOUT=8, never assert done.
  - fault=1 exactly 8 cycles after Run.
  - start clears fault and refetches address 0.
- Boundary/simultaneous: done and imm_req in the same cycle → pc+1 fetch, no imm_valid.
  - Last-address done without a halt word → fault.
- Reset mid-EXEC: drop Resetn asynchronously between clock edges.
  - All outputs reset immediately.
  - No Run until start after release.
